// File: rtl/trsq_pkg.sv
// rtl/trsq_pkg.sv - shared defaults, action encoding and priority encoder for the TRSQ sequencer
// Contents:
//   PC_W_DEF, VEC_BASE_DEF, VEC_STRIDE_DEF : default sequencer geometry
//   IRQ_MAX, IRQ_IDX_W                     : widest supported interrupt set and its index width
//   act_e                                  : the single PC action chosen each cycle
//   prio_t / prio_enc                      : lowest-set-bit encoder with a valid flag
package trsq_pkg;

  localparam int PC_W_DEF       = 13;
  localparam int VEC_BASE_DEF   = 4;
  localparam int VEC_STRIDE_DEF = 2;
  localparam int IRQ_MAX        = 8;
  localparam int IRQ_IDX_W      = 3;

  // Exactly one action wins per edge; its side effects (stack, flags) are the only ones applied.
  typedef enum logic [2:0] {
    ACT_STEP,
    ACT_TAKE,
    ACT_HALT,
    ACT_JUMP,
    ACT_CALL,
    ACT_RET,
    ACT_RETI,
    ACT_SKIP
  } act_e;

  typedef struct packed {
    logic                 valid;
    logic [IRQ_IDX_W-1:0] idx;
  } prio_t;

  // Scans from the top down so the last assignment left standing is the lowest set bit.
  function automatic prio_t prio_enc(input logic [IRQ_MAX-1:0] req);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = IRQ_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/trsq_ret_stack.sv
// rtl/trsq_ret_stack.sv - parametrised LIFO return stack shared by call and interrupt entry
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears occupancy only)
//   push, push_data : write push_data on top; ignored when full
//   pop             : drop the top entry; ignored when empty
//   top_data        : entry at sp-1 (don't-care when empty)
//   sp              : occupancy 0..DEPTH
//   full, empty     : occupancy status
module trsq_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 13,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_data,
  output logic [W-1:0]    top_data,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full     = (sp == SP_W'(DEPTH));
  assign empty    = (sp == '0);
  assign wr_idx   = AW'(sp);
  assign rd_idx   = AW'(sp - SP_W'(1));
  assign top_data = mem[rd_idx];

  // Entry storage needs no reset: anything at or above sp is never read as valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/trsq_seq.sv
// rtl/trsq_seq.sv - program sequencer: PC, return stack and vectored interrupt controller
// Ports:
//   clk_ip, reset_ip              : clock, synchronous active-high reset
//   halt/jump/call/ret/reti/skip  : decoder control strobes, resolved by fixed priority
//   target_ip                     : jump/call destination
//   irq_ip                        : synchronous request lines, rising-edge detected into pending
//   en_wr_ip, en_data_ip          : interrupt enable mask write
//   gie_set_ip, gie_clr_ip        : global interrupt enable control (clear wins)
//   pc_op                         : registered fetch address
//   flush_op                      : interrupt taken this cycle, squash instruction at pc_op
//   irq_ack_op                    : one-cycle one-hot pulse for the channel taken
//   irq_pend_op, gie_op, sp_op    : pending mask, global enable, stack occupancy
//   stack_ovf_op, stack_unf_op    : sticky stack error flags
module trsq_seq
  import trsq_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int STACK_DEPTH = 4,
  parameter int IRQ_N       = 4,
  parameter int VEC_BASE    = VEC_BASE_DEF,
  parameter int VEC_STRIDE  = VEC_STRIDE_DEF,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk_ip,
  input  logic             reset_ip,
  input  logic             halt_ip,
  input  logic             jump_ip,
  input  logic             call_ip,
  input  logic             ret_ip,
  input  logic             reti_ip,
  input  logic             skip_ip,
  input  logic [PC_W-1:0]  target_ip,
  input  logic [IRQ_N-1:0] irq_ip,
  input  logic             en_wr_ip,
  input  logic [IRQ_N-1:0] en_data_ip,
  input  logic             gie_set_ip,
  input  logic             gie_clr_ip,
  output logic [PC_W-1:0]  pc_op,
  output logic             flush_op,
  output logic [IRQ_N-1:0] irq_ack_op,
  output logic [IRQ_N-1:0] irq_pend_op,
  output logic             gie_op,
  output logic [SP_W-1:0]  sp_op,
  output logic             stack_ovf_op,
  output logic             stack_unf_op
);

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W-1:0]  vec;
  logic [IRQ_N-1:0] en;
  logic [IRQ_N-1:0] pend;
  logic [IRQ_N-1:0] irq_prev;
  logic [IRQ_N-1:0] ack;
  logic [IRQ_N-1:0] rise;
  logic [IRQ_N-1:0] take_mask;
  logic             gie;
  logic             ovf;
  logic             unf;
  logic             take;
  prio_t            sel;
  act_e             act;

  logic             st_push;
  logic             st_pop;
  logic [PC_W-1:0]  st_din;
  logic [PC_W-1:0]  st_top;
  logic [SP_W-1:0]  st_sp;
  logic             st_full;
  logic             st_empty;
  logic             set_ovf;
  logic             set_unf;
  logic             reti_gie;

  trsq_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W),
    .SP_W  (SP_W)
  ) u_stack (
    .clk       (clk_ip),
    .reset     (reset_ip),
    .push      (st_push),
    .pop       (st_pop),
    .push_data (st_din),
    .top_data  (st_top),
    .sp        (st_sp),
    .full      (st_full),
    .empty     (st_empty)
  );

  assign pc_inc = pc + PC_W'(1);
  assign rise   = irq_ip & ~irq_prev;

  // take uses registered state only, so a request is never taken on the edge that latches it.
  assign sel  = prio_enc(IRQ_MAX'(pend & en));
  assign take = gie & sel.valid & ~st_full;
  assign vec  = PC_W'(VEC_BASE + VEC_STRIDE * int'(sel.idx));

  assign take_mask = take ? (IRQ_N'(1) << sel.idx) : '0;

  always_comb begin
    if (take)         act = ACT_TAKE;
    else if (halt_ip) act = ACT_HALT;
    else if (jump_ip) act = ACT_JUMP;
    else if (call_ip) act = ACT_CALL;
    else if (ret_ip)  act = ACT_RET;
    else if (reti_ip) act = ACT_RETI;
    else if (skip_ip) act = ACT_SKIP;
    else              act = ACT_STEP;
  end

  always_comb begin
    pc_next  = pc_inc;
    st_push  = 1'b0;
    st_pop   = 1'b0;
    st_din   = pc_inc;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    reti_gie = 1'b0;
    case (act)
      ACT_TAKE: begin
        // The squashed instruction at pc is re-executed after reti, so pc itself is stacked.
        pc_next = vec;
        st_push = 1'b1;
        st_din  = pc;
      end
      ACT_HALT: pc_next = pc;
      ACT_JUMP: pc_next = target_ip;
      ACT_CALL: begin
        pc_next = target_ip;
        if (st_full) set_ovf = 1'b1;
        else         st_push = 1'b1;
      end
      ACT_RET, ACT_RETI: begin
        reti_gie = (act == ACT_RETI);
        if (st_empty) begin
          set_unf = 1'b1;
        end else begin
          st_pop  = 1'b1;
          pc_next = st_top;
        end
      end
      ACT_SKIP: pc_next = pc + PC_W'(2);
      default:  pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      pc       <= '0;
      gie      <= 1'b0;
      en       <= '0;
      pend     <= '0;
      ack      <= '0;
      irq_prev <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      pc       <= pc_next;
      irq_prev <= irq_ip;
      // A new edge on the channel being taken survives the clear.
      pend     <= (pend & ~take_mask) | rise;
      ack      <= take_mask;
      if (en_wr_ip) en <= en_data_ip;
      if (take || gie_clr_ip)           gie <= 1'b0;
      else if (gie_set_ip || reti_gie)  gie <= 1'b1;
      if (set_ovf) ovf <= 1'b1;
      if (set_unf) unf <= 1'b1;
    end
  end

  assign pc_op        = pc;
  assign flush_op     = take;
  assign irq_ack_op   = ack;
  assign irq_pend_op  = pend;
  assign gie_op       = gie;
  assign sp_op        = st_sp;
  assign stack_ovf_op = ovf;
  assign stack_unf_op = unf;

endmodule
